// File: rtl/mem_image_loader.sv
// mem_image_loader: boot-time image writer for the CPU's unified memory.
// Parses framed bytes (A5, CMD, LEN_HI, LEN_LO, LEN*4 payload bytes, MSB
// first), writes big-endian words into the text or data segment, and
// releases the CPU from reset when the DONE command (CMD=FF) arrives.
// Optional build macro CHECKSUM_EN: each text/data frame with LEN>0 carries
// one trailing XOR-of-payload byte, checked in a CHECK state after the last
// write. A LEN=0 frame ends at LEN_LO and carries no checksum byte.
module mem_image_loader #(
  parameter int             AW        = 16,
  parameter logic [AW-1:0]  TEXT_BASE = AW'(16'h0000),
  parameter logic [AW-1:0]  DATA_BASE = AW'(16'h2000),
  parameter logic [15:0]    MAX_WORDS = 16'h0FFF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          err,
  output logic [15:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          live_q;     // low for the first cycle after reset release
  logic [AW-1:0] ptr_q;
  logic [15:0]   rem_q;
  logic [1:0]    bcnt_q;
  logic [31:0]   word_q;
  logic [7:0]    lenhi_q;
  logic          err_q;
  logic [15:0]   wcnt_q;
  logic          err_set;
  logic          acc;
  logic [15:0]   len;
`ifdef CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  assign acc = in_valid && in_ready;
  assign len = {lenhi_q, in_data};

  // Output decode; memory-side fields come straight from the datapath regs
  always_comb begin
    in_ready      = live_q && (state_q != S_WRITE) && (state_q != S_DONE);
    mem_we        = (state_q == S_WRITE);
    mem_addr      = ptr_q;
    mem_wdata     = word_q;
    cpu_run       = (state_q == S_DONE);
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    err           = err_q;
    words_written = wcnt_q;
  end

  // Next-state and error detection; only accepted bytes advance the parser
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: if (acc) begin
        if (in_data == 8'hA5) state_d = S_CMD;
        else                  err_set = 1'b1;
      end
      S_CMD: if (acc) begin
        case (in_data)
          8'h00, 8'h01: state_d = S_LEN_HI;
          8'hFF:        state_d = S_DONE;
          default: begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_LEN_HI: if (acc) state_d = S_LEN_LO;
      S_LEN_LO: if (acc) begin
        if (len == 16'd0) state_d = S_IDLE;
        else if (len > MAX_WORDS) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (acc && bcnt_q == 2'd3) state_d = S_WRITE;
`ifdef CHECKSUM_EN
      S_WRITE: state_d = (rem_q != 16'd1) ? S_PAYLOAD : S_CHECK;
      S_CHECK: if (acc) begin
        if (in_data != csum_q) err_set = 1'b1;
        state_d = S_IDLE;
      end
`else
      S_WRITE: state_d = (rem_q != 16'd1) ? S_PAYLOAD : S_IDLE;
`endif
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and the one-cycle post-reset ready holdoff
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Datapath: segment pointer, length, word assembly and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      lenhi_q <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      if (err_set) err_q <= 1'b1;
      if (acc) begin
        case (state_q)
          S_CMD:    ptr_q   <= (in_data == 8'h01) ? DATA_BASE : TEXT_BASE;
          S_LEN_HI: lenhi_q <= in_data;
          S_LEN_LO: begin
            rem_q  <= len;
            bcnt_q <= 2'd0;
`ifdef CHECKSUM_EN
            csum_q <= 8'h00;
`endif
          end
          S_PAYLOAD: begin
            word_q <= {word_q[23:0], in_data};
            bcnt_q <= bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
          default: ;
        endcase
      end
      if (state_q == S_WRITE) begin
        ptr_q <= ptr_q + AW'(1);
        rem_q <= rem_q - 16'd1;
        if (wcnt_q != 16'hFFFF) wcnt_q <= wcnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: randomized frame stimulus against a frame-level
// reference (expected write list built from each frame's segment base and
// words), plus directed error, boundary, reset-abort and DONE scenarios.
module tb_mem_image_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_run, busy, err;
  logic [15:0] mem_addr, words_written;
  logic [31:0] mem_wdata;

  int n_checks = 0;
  int n_err = 0;
  int ready_low = 0;
  logic [47:0] wq[$];     // observed writes {addr, data}
  logic [47:0] exp_q[$];  // expected writes from the reference
  logic [31:0] fw[$];     // words of the frame being sent

  mem_image_loader dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Capture writes and count not-ready cycles, away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    if (reset_n && in_ready === 1'b0 && cpu_run === 1'b0) ready_low++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer a byte after 'gap' idle cycles and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send a text/data frame carrying fw[], appending expected writes
  task automatic send_frame(input logic [7:0] cmd, input int maxgap);
    logic [15:0] base;
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  b;
    base = (cmd == 8'h01) ? 16'h2000 : 16'h0000;
    n = 16'(fw.size());
    cs = 8'h00;
    send_byte(8'hA5, int'($urandom_range(maxgap, 0)));
    send_byte(cmd, int'($urandom_range(maxgap, 0)));
    send_byte(n[15:8], int'($urandom_range(maxgap, 0)));
    send_byte(n[7:0], int'($urandom_range(maxgap, 0)));
    foreach (fw[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = fw[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, int'($urandom_range(maxgap, 0)));
      end
      exp_q.push_back({base + 16'(i), fw[i]});
    end
`ifdef CHECKSUM_EN
    send_byte(cs, int'($urandom_range(maxgap, 0)));
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #7;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_written} !== 69'd0) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%h wd=%h run=%b busy=%b err=%b ww=%h required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_written);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge got %b required 1", in_ready);
    end
  endtask

  task automatic test_text_frame();
    int ws, rl;
    do_reset();
    exp_q.delete();
    ws = wq.size();
    rl = ready_low;
    fw = {32'h20080010, 32'h8C090000};
    send_frame(8'h00, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wq.size() - ws != exp_q.size()) begin
      n_err++;
      $display("FAIL text_write_count got %0d required %0d", wq.size() - ws, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ws + i < wq.size(); i++) begin
      n_checks++;
      if (wq[ws+i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL text_write[%0d] got %h required %h", i, wq[ws+i], exp_q[i]);
      end
    end
    n_checks++;
    if (words_written !== 16'd2 || err !== 1'b0) begin
      n_err++;
      $display("FAIL text_status got ww=%0d err=%b required ww=2 err=0", words_written, err);
    end
    n_checks++;
    if (ready_low - rl != 2) begin
      n_err++;
      $display("FAIL text_ready_low_cycles got %0d required 2", ready_low - rl);
    end
  endtask

  task automatic test_error();
    int ws;
    do_reset();
    exp_q.delete();
    ws = wq.size();
    send_byte(8'h3C, 0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bad_sync got err=%b busy=%b required err=1 busy=0", err, busy);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h07, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || wq.size() != ws) begin
      n_err++;
      $display("FAIL bad_cmd got busy=%b err=%b writes=%0d required busy=0 err=1 writes=0",
               busy, err, wq.size() - ws);
    end
    fw = {$urandom, $urandom};
    send_frame(8'h01, 1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wq.size() - ws != exp_q.size()) begin
      n_err++;
      $display("FAIL recover_write_count got %0d required %0d", wq.size() - ws, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ws + i < wq.size(); i++) begin
      n_checks++;
      if (wq[ws+i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL recover_write[%0d] got %h required %h", i, wq[ws+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    int ws;
    logic [47:0] run_a[$];
    logic [31:0] words[$];
    words = {$urandom, $urandom, $urandom};
    // back-to-back reference run
    do_reset();
    exp_q.delete();
    ws = wq.size();
    fw = words;
    send_frame(8'h00, 0);
    repeat (2) @(negedge clk);
    for (int i = ws; i < wq.size(); i++) run_a.push_back(wq[i]);
    // same frame with random stalls
    do_reset();
    exp_q.delete();
    ws = wq.size();
    fw = words;
    send_frame(8'h00, 3);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wq.size() - ws != 3 || run_a.size() != 3) begin
      n_err++;
      $display("FAIL gaps_write_count got %0d/%0d required 3/3", run_a.size(), wq.size() - ws);
    end
    for (int i = 0; i < 3 && ws + i < wq.size() && i < run_a.size(); i++) begin
      n_checks++;
      if (wq[ws+i] !== exp_q[i] || run_a[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gaps_write[%0d] got stall=%h b2b=%h required %h", i, wq[ws+i], run_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int ws;
    do_reset();
    exp_q.delete();
    ws = wq.size();
    for (int f = 0; f < 5; f++) begin
      fw.delete();
      for (int j = 0; j < int'($urandom_range(3, 1)); j++) fw.push_back($urandom);
      send_frame($urandom_range(1, 0) ? 8'h01 : 8'h00, 2);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wq.size() - ws != exp_q.size() || words_written !== 16'(exp_q.size())) begin
      n_err++;
      $display("FAIL rand_write_count got %0d ww=%0d required %0d", wq.size() - ws, words_written, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ws + i < wq.size(); i++) begin
      n_checks++;
      if (wq[ws+i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rand_write[%0d] got %h required %h", i, wq[ws+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_len_bounds();
    int ws;
    do_reset();
    ws = wq.size();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL len_zero got busy=%b err=%b required busy=0 err=0", busy, err);
    end
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || wq.size() != ws) begin
      n_err++;
      $display("FAIL len_over got busy=%b err=%b writes=%0d required busy=0 err=1 writes=0",
               busy, err, wq.size() - ws);
    end
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h0F, 0); send_byte(8'hFF, 0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL len_max got busy=%b err=%b required busy=1 err=0", busy, err);
    end
  endtask

  task automatic test_reset_midframe();
    int ws;
    logic [31:0] words[$];
    do_reset();
    ws = wq.size();
    words = {$urandom, $urandom, $urandom};
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(words[i/4][8*(3 - i%4) +: 8], 0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_written} !== 69'd0) begin
      n_err++;
      $display("FAIL abort_values got rdy=%b we=%b addr=%h wd=%h run=%b busy=%b err=%b ww=%h required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_written);
    end
    n_checks++;
    if (wq.size() - ws != 1 || wq[ws] !== {16'h0000, words[0]}) begin
      n_err++;
      $display("FAIL abort_partial got writes=%0d first=%h required 1 of %h",
               wq.size() - ws, wq[ws], {16'h0000, words[0]});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    ws = wq.size();
    fw = words;
    send_frame(8'h00, 1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wq.size() - ws != 3 || words_written !== 16'd3) begin
      n_err++;
      $display("FAIL resend_count got %0d ww=%0d required 3", wq.size() - ws, words_written);
    end
    for (int i = 0; i < exp_q.size() && ws + i < wq.size(); i++) begin
      n_checks++;
      if (wq[ws+i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL resend_write[%0d] got %h required %h", i, wq[ws+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_done();
    int ws;
    do_reset();
    exp_q.delete();
    ws = wq.size();
    fw = {32'hDEADBEEF};
    send_frame(8'h01, 0);
    send_byte(8'hA5, 0);
    n_checks++;
    if (cpu_run !== 1'b0) begin
      n_err++;
      $display("FAIL run_early got %b required 0", cpu_run);
    end
    send_byte(8'hFF, 0);
    @(negedge clk);
    n_checks++;
    if (cpu_run !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_state got run=%b rdy=%b busy=%b required run=1 rdy=0 busy=0",
               cpu_run, in_ready, busy);
    end
    n_checks++;
    if (wq.size() - ws != 1 || wq[ws] !== exp_q[0]) begin
      n_err++;
      $display("FAIL done_write got %0d writes first=%h required 1 of %h", wq.size() - ws, wq[ws], exp_q[0]);
    end
    in_valid = 1'b1;
    in_data = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || cpu_run !== 1'b1 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL done_hold[%0d] got rdy=%b run=%b we=%b required 0 1 0", i, in_ready, cpu_run, mem_we);
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    int ws;
    do_reset();
    ws = wq.size();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL csum_good got err=%b busy=%b required 0 0", err, busy);
    end
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL csum_bad got err=%b required 1", err);
    end
    n_checks++;
    if (wq.size() - ws != 2 || wq[ws+1] !== {16'h0000, 32'h01020304}) begin
      n_err++;
      $display("FAIL csum_write got %0d writes last=%h required 2 of 000001020304",
               wq.size() - ws, wq[wq.size()-1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_text_frame();
    test_error();
    test_gaps();
    test_random_frames();
    test_len_bounds();
    test_reset_midframe();
    test_done();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
